hilo_multiplier: RTL and testbench

HILO_MULTIPLIER -- requirements
Module: hilo_multiplier

---
 rtl/hilo_multiplier_if.sv | 40 ++++
 rtl/hilo_multiplier.sv | 126 ++++++++++++
 tb/tb_hilo_multiplier.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_multiplier_if.sv
// ---------------------------------------------------------------------------
// hilo_multiplier_if
//   Groups the request, status and result signals of the HI/LO multiply
//   unit. Clock and reset stay outside the bundle as plain ports.
//
//   start   decoder-issued MULTU request
//   srca    multiplicand (rs value)
//   srcb    multiplier (rt value)
//   rdsel   result select: 0 = LO (mflo), 1 = HI (mfhi)
//   busy    stall request while a multiply is in flight
//   done    one-cycle pulse marking the HI/LO commit
//   hi, lo  architectural HI / LO registers
//   result  combinational HI/LO read mux
//
//   master: the datapath/decoder side that issues requests.
//   slave : the multiply unit.
// ---------------------------------------------------------------------------
interface hilo_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             rdsel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, srca, srcb, rdsel,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  start, srca, srcb, rdsel,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/hilo_multiplier.sv
// ---------------------------------------------------------------------------
// hilo_multiplier
//   Fixed-latency unsigned shift-add multiplier feeding the architectural
//   HI/LO registers (MULTU). A request is accepted in IDLE or DONE, runs for
//   exactly WIDTH cycles in RUN with busy asserted, then commits the full
//   2*WIDTH-bit product to hi/lo and pulses done for one cycle.
//
//   Ports:
//     clk    single clock, rising-edge
//     reset  asynchronous, active-low; aborts any operation, clears hi/lo
//     bus    hilo_multiplier_if.slave (start, srca, srcb, rdsel in;
//            busy, done, hi, lo, result out)
// ---------------------------------------------------------------------------
module hilo_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hilo_multiplier_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Product accumulator. The lower half starts out holding the multiplier:
  // each step consumes the multiplier LSB at bit 0 and shifts a finished
  // product bit in from the top, so after WIDTH steps the whole register
  // is the product. The upper half is the cleared partial-sum part.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Upper-half add with carry kept: WIDTH+1 bits, so nothing is truncated.
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     addend;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    addend  = acc_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d = bus.srca;
          acc_d   = {{WIDTH{1'b0}}, bus.srcb};
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // start is deliberately not looked at here: the op in flight runs
        // to completion with the operands latched at acceptance.
        acc_d = {sum, acc_q[WIDTH-1:1]};
        if (cnt_q == LAST_ITER) begin
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status outputs are registered alongside the state so they track it
    // exactly, with no decode glitches.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = bus.rdsel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_multiplier.sv
// ---------------------------------------------------------------------------
// tb_hilo_multiplier
//   Directed bench for hilo_multiplier: a table of operand pairs with
//   hand-computed HI/LO values, plus sequences for start-during-RUN,
//   mid-run reset, back-to-back issue from DONE and start right after reset.
// ---------------------------------------------------------------------------
module tb_hilo_multiplier;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  hilo_multiplier_if #(.WIDTH(WIDTH)) bus ();

  hilo_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts busy cycles from the current negedge until busy drops (bounded).
  task automatic wait_busy(output int busy_cnt);
    busy_cnt = 0;
    while (bus.busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
  endtask

  // Issues one multiply, scrambles operands after the latching edge, and
  // watches that hi/lo hold and done stays low while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output logic done_seen,
                        output logic hold_ok);
    logic [31:0] ph, pl;
    @(negedge clk);
    ph = bus.hi;
    pl = bus.lo;
    bus.start = 1'b1;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = ~a;
    bus.srcb  = ~b;
    busy_cnt  = 0;
    hold_ok   = 1'b1;
    while (bus.busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      if (bus.hi !== ph || bus.lo !== pl || bus.done !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    done_seen = bus.done;
  endtask

  vec_t vecs[10];

  initial begin
    int          bc;
    logic        dn;
    logic        hold;
    int          pulses;
    int          guard;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{32'hAAAA_AAAA, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[8] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[9] = '{32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 32'h0000_0031};

    bus.start = 1'b0;
    bus.srca  = '0;
    bus.srcb  = '0;
    bus.rdsel = 1'b0;
    reset     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_hi",   bus.hi,   32'h0);
    check("reset_lo",   bus.lo,   32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    // Table-driven products
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, bc, dn, hold);
      check($sformatf("v%0d_busy_cycles", i), bc, 32);
      check($sformatf("v%0d_hold", i), hold, 1'b1);
      check($sformatf("v%0d_done", i), dn, 1'b1);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
      bus.rdsel = 1'b0;
      #1;
      check($sformatf("v%0d_result_lo", i), bus.result, vecs[i].exp_lo);
      bus.rdsel = 1'b1;
      #1;
      check($sformatf("v%0d_result_hi", i), bus.result, vecs[i].exp_hi);
      bus.rdsel = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_done_drop", i), bus.done, 1'b0);
      check($sformatf("v%0d_idle_busy", i), bus.busy, 1'b0);
    end

    // start held high with new operands during RUN: ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.srca  = 32'd3;
    bus.srcb  = 32'd5;
    @(negedge clk);
    bus.srca  = 32'd7;
    bus.srcb  = 32'd7;
    repeat (20) @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("hold_start_pulses", pulses, 1);
    check("hold_start_lo", bus.lo, 32'd15);
    check("hold_start_hi", bus.hi, 32'd0);

    // Back-to-back: new request issued during the DONE cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.srca  = 32'd3;
    bus.srcb  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    check("b2b_first_done", bus.done, 1'b1);
    check("b2b_first_lo", bus.lo, 32'd15);
    bus.start = 1'b1;
    bus.srca  = 32'd4;
    bus.srcb  = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_next", bus.busy, 1'b1);
    check("b2b_done_next", bus.done, 1'b0);
    check("b2b_lo_held", bus.lo, 32'd15);
    wait_busy(bc);
    check("b2b_busy_cycles", bc, 32);
    check("b2b_second_done", bus.done, 1'b1);
    check("b2b_second_lo", bus.lo, 32'd24);
    check("b2b_second_hi", bus.hi, 32'd0);

    // Reset asserted at iteration 10: abort, no commit, no done
    @(negedge clk);
    bus.start = 1'b1;
    bus.srca  = 32'hFFFF_FFFF;
    bus.srcb  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_activity", pulses, 0);
    check("abort_hi_after", bus.hi, 32'h0);
    check("abort_lo_after", bus.lo, 32'h0);

    // start sampled on the first edge after reset release
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.srca  = 32'd2;
    bus.srcb  = 32'd3;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_reset_busy", bus.busy, 1'b1);
    wait_busy(bc);
    check("post_reset_busy_cycles", bc, 32);
    check("post_reset_done", bus.done, 1'b1);
    check("post_reset_lo", bus.lo, 32'd6);
    check("post_reset_hi", bus.hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
